// File: rtl/arb_req_frontend.sv
// Request front end for a 2-client arbiter: per-client FIFOs, occupancy-driven requests, grant-driven pops.
// Optional per-client starvation counters when ARB_FE_STARVE_CNT_EN is defined.

module arb_fe_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              ready,
    output logic              not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Ready is purely registered: a full FIFO stays not-ready in the cycle it is popped.
    assign ready     = (count != CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign head      = mem[rd_ptr];

endmodule

module arb_req_frontend #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    output logic [1:0]        request,
    input  logic [1:0]        grant,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
`ifdef ARB_FE_STARVE_CNT_EN
    ,
    output logic [7:0]        starve0,
    output logic [7:0]        starve1
`endif
);

    logic              push0;
    logic              push1;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic [1:0]        elig;
    logic              pop_en;
    logic              sel;
    logic              last_src;

    assign push0 = in0_valid && in0_ready;
    assign push1 = in1_valid && in1_ready;

    arb_fe_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in0_data),
        .pop       (pop0),
        .head      (head0),
        .ready     (in0_ready),
        .not_empty (request[0])
    );

    arb_fe_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in1_data),
        .pop       (pop1),
        .head      (head1),
        .ready     (in1_ready),
        .not_empty (request[1])
    );

    // Grants aimed at empty FIFOs are dropped; a double grant goes to the client not served last.
    assign elig = grant & request;

    always_comb begin
        pop_en = 1'b0;
        sel    = 1'b0;
        case (elig)
            2'b01: begin
                pop_en = 1'b1;
                sel    = 1'b0;
            end
            2'b10: begin
                pop_en = 1'b1;
                sel    = 1'b1;
            end
            2'b11: begin
                pop_en = 1'b1;
                sel    = ~last_src;
            end
            default: begin
                pop_en = 1'b0;
                sel    = 1'b0;
            end
        endcase
    end

    assign pop0 = pop_en && !sel;
    assign pop1 = pop_en && sel;

    // last_src resets to 1 so that client 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last_src  <= 1'b1;
        end else if (pop_en) begin
            out_valid <= 1'b1;
            out_data  <= sel ? head1 : head0;
            out_src   <= sel;
            last_src  <= sel;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_FE_STARVE_CNT_EN
    // Cycles a client has waited with a pending request since its last pop, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve0 <= 8'd0;
            starve1 <= 8'd0;
        end else begin
            if (pop0) begin
                starve0 <= 8'd0;
            end else if (request[0] && (starve0 != 8'hFF)) begin
                starve0 <= starve0 + 8'd1;
            end
            if (pop1) begin
                starve1 <= 8'd0;
            end else if (request[1] && (starve1 != 8'hFF)) begin
                starve1 <= starve1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arb_req_frontend.sv
// Self-checking bench for arb_req_frontend: scoreboard of expected {src,data} beats plus per-scenario checks.
// Starve-counter scenario is included when ARB_FE_STARVE_CNT_EN is defined.

module tb_arb_req_frontend;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] in1_data;
    logic [1:0]        request;
    logic [1:0]        grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
`ifdef ARB_FE_STARVE_CNT_EN
    logic [7:0]        starve0;
    logic [7:0]        starve1;
`endif

    int checks = 0;
    int errors = 0;

    // Expected output beats, {src, data}, oldest first.
    logic [DATA_W:0] sb [$];

    arb_req_frontend #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef ARB_FE_STARVE_CNT_EN
        ,
        .starve0   (starve0),
        .starve1   (starve1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every output beat must match the oldest expected entry; unexpected beats are errors.
    always @(negedge clk) begin
        logic [DATA_W:0] exp_beat;
        if (out_valid !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat: out_valid=%b src=%0d data=%02h, required no beat",
                         out_valid, out_src, out_data);
            end else begin
                exp_beat = sb.pop_front();
                if ({out_src, out_data} !== exp_beat) begin
                    errors++;
                    $display("[TB] FAIL beat: got src=%0d data=%02h, required src=%0d data=%02h",
                             out_src, out_data, exp_beat[DATA_W], exp_beat[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drained: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 8'h77;
        in1_valid = 1'b1;
        in1_data  = 8'h88;
        grant     = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({request, in0_ready, in1_ready, out_valid} !== 5'b00_1_1_0) begin
                errors++;
                $display("[TB] FAIL reset_state: req=%b rdy0=%b rdy1=%b ov=%b, required req=00 rdy=1,1 ov=0",
                         request, in0_ready, in1_ready, out_valid);
            end
        end
        checks++;
        if ({out_src, out_data} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL reset_out: src=%0d data=%02h, required 0/00", out_src, out_data);
        end
        reset     = 1'b0;
        in1_valid = 1'b0;
        grant     = 2'b00;
        @(negedge clk);
        in0_valid = 1'b0;
        checks++;
        if (request !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_first_push: request=%b, required 01", request);
        end
        sb.push_back({1'b0, 8'h77});
        grant = 2'b01;
        @(negedge clk);
        grant = 2'b00;
        @(negedge clk);
        drained("reset");
    endtask

    task automatic test_single();
        in0_valid = 1'b1;
        in0_data  = 8'h11;
        @(negedge clk);
        in0_data  = 8'h22;
        @(negedge clk);
        in0_valid = 1'b0;
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b0, 8'h22});
        grant = 2'b01;
        @(negedge clk);
        checks++;
        if (request !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_req_mid: request=%b, required 01", request);
        end
        @(negedge clk);
        checks++;
        if (request !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_req_fall: request=%b, required 00", request);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle: out_valid=%b, required 0", out_valid);
        end
        grant = 2'b00;
        drained("single");
    endtask

    task automatic test_reset_mid();
        in0_valid = 1'b1;
        in0_data  = 8'h99;
        in1_valid = 1'b1;
        in1_data  = 8'hAA;
        @(negedge clk);
        checks++;
        if (request !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midreset_fill: request=%b, required 11", request);
        end
        reset = 1'b1;
        grant = 2'b11;
        @(negedge clk);
        checks++;
        if ({request, in0_ready, in1_ready, out_valid} !== 5'b00_1_1_0) begin
            errors++;
            $display("[TB] FAIL midreset_state: req=%b rdy0=%b rdy1=%b ov=%b, required req=00 rdy=1,1 ov=0",
                     request, in0_ready, in1_ready, out_valid);
        end
        reset     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({request, out_valid} !== 3'b00_0) begin
            errors++;
            $display("[TB] FAIL midreset_discard: req=%b ov=%b, required req=00 ov=0", request, out_valid);
        end
        grant = 2'b00;
        drained("midreset");
    endtask

    task automatic test_tiebreak();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_data  = 8'hB0;
        @(negedge clk);
        in0_data  = 8'hA1;
        in1_data  = 8'hB1;
        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        sb.push_back({1'b0, 8'hA0});
        sb.push_back({1'b1, 8'hB0});
        sb.push_back({1'b0, 8'hA1});
        sb.push_back({1'b1, 8'hB1});
        grant = 2'b11;
        repeat (4) @(negedge clk);
        grant = 2'b00;
        @(negedge clk);
        checks++;
        if (request !== 2'b00) begin
            errors++;
            $display("[TB] FAIL tie_empty: request=%b, required 00", request);
        end
        drained("tie");
    endtask

    task automatic test_full();
        logic [7:0] words [5];
        words = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_data = words[i];
            @(negedge clk);
            checks++;
            if (in1_ready !== (i < 3)) begin
                errors++;
                $display("[TB] FAIL full_ready_%0d: in1_ready=%b, required %b", i, in1_ready, (i < 3));
            end
        end
        in1_data = words[4];
        @(negedge clk);
        checks++;
        if ({in1_ready, request} !== 3'b0_10) begin
            errors++;
            $display("[TB] FAIL full_hold: in1_ready=%b request=%b, required 0/10", in1_ready, request);
        end
        sb.push_back({1'b1, words[0]});
        grant = 2'b10;
        @(negedge clk);
        grant = 2'b00;
        checks++;
        if (in1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_ready_after_pop: in1_ready=%b, required 1", in1_ready);
        end
        @(negedge clk);
        in1_valid = 1'b0;
        checks++;
        if (in1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_refill: in1_ready=%b, required 0", in1_ready);
        end
        for (int i = 1; i < 5; i++) begin
            sb.push_back({1'b1, words[i]});
        end
        grant = 2'b10;
        repeat (4) @(negedge clk);
        grant = 2'b00;
        @(negedge clk);
        checks++;
        if (request !== 2'b00) begin
            errors++;
            $display("[TB] FAIL full_empty: request=%b, required 00", request);
        end
        drained("full");
    endtask

    task automatic test_spurious();
        in1_valid = 1'b1;
        in1_data  = 8'h5C;
        @(negedge clk);
        in1_valid = 1'b0;
        grant = 2'b01;
        @(negedge clk);
        checks++;
        if ({out_valid, request} !== 3'b0_10) begin
            errors++;
            $display("[TB] FAIL spurious_grant: out_valid=%b request=%b, required 0/10", out_valid, request);
        end
        sb.push_back({1'b1, 8'h5C});
        grant = 2'b11;
        @(negedge clk);
        grant = 2'b00;
        @(negedge clk);
        checks++;
        if (request !== 2'b00) begin
            errors++;
            $display("[TB] FAIL spurious_empty: request=%b, required 00", request);
        end
        drained("spurious");
    endtask

    task automatic test_back_to_back();
        grant     = 2'b01;
        in0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in0_data = 8'hD0 + 8'(i);
            sb.push_back({1'b0, in0_data});
            @(negedge clk);
            checks++;
            if ({request, in0_ready} !== 3'b01_1) begin
                errors++;
                $display("[TB] FAIL b2b_stream_%0d: request=%b in0_ready=%b, required 01/1", i, request, in0_ready);
            end
        end
        in0_valid = 1'b0;
        @(negedge clk);
        grant = 2'b00;
        @(negedge clk);
        checks++;
        if (request !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_empty: request=%b, required 00", request);
        end
        drained("b2b");
    endtask

`ifdef ARB_FE_STARVE_CNT_EN
    task automatic test_starve();
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'hE5;
        @(negedge clk);
        in0_valid = 1'b0;
        checks++;
        if ({starve0, starve1} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL starve_start: starve0=%0d starve1=%0d, required 0/0", starve0, starve1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (starve0 !== 8'd10) begin
            errors++;
            $display("[TB] FAIL starve_count: starve0=%0d, required 10", starve0);
        end
        repeat (290) @(negedge clk);
        checks++;
        if (starve0 !== 8'd255) begin
            errors++;
            $display("[TB] FAIL starve_sat: starve0=%0d, required 255", starve0);
        end
        sb.push_back({1'b0, 8'hE5});
        grant = 2'b01;
        @(negedge clk);
        grant = 2'b00;
        checks++;
        if (starve0 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL starve_clear: starve0=%0d, required 0", starve0);
        end
        @(negedge clk);
        drained("starve");
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        grant     = 2'b00;
        test_reset();
        test_single();
        test_reset_mid();
        test_tiebreak();
        test_full();
        test_spurious();
        test_back_to_back();
`ifdef ARB_FE_STARVE_CNT_EN
        test_starve();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_req_frontend.md
# arb_req_frontend

- Upstream request stage for the 2-client arbiter.
- Buffers transactions from two clients in per-client FIFOs and drives `request[1:0]` to the arbiter from FIFO occupancy.
- Consumes the returned `grant[1:0]` to pop the selected client's head word onto a single shared output bus.
- Serialises any multi-bit grant with a round-robin tie-break.

## Interface
- `DATA_W`, 8 — width of client and output data.
- `DEPTH`, 4 — entries per client FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `in0_valid`  in  1  — client 0 offers `in0_data`.
- `in0_ready`  out  1  — FIFO 0 not full.
- `in0_data`  in  DATA_W  — client 0 payload.
- `in1_valid`  in  1  — client 1 offers `in1_data`.
- `in1_ready`  out  1  — FIFO 1 not full.
- `in1_data`  in  DATA_W  — client 1 payload.
- `request`  out  2  — to arbiter; bit i = FIFO i non-empty.
- `grant`  in  2  — from arbiter; bit i grants client i.
- `out_valid`  out  1  — `out_data`/`out_src` valid this cycle.
- `out_data`  out  DATA_W  — popped word.
- `out_src`  out  1  — client index of the popped word.

## Operation
- Two independent FIFOs, each with:
  - `DEPTH` entries;
  - wrapping read/write pointers of `log2(DEPTH)` bits;
  - a `log2(DEPTH)+1`-bit count.
- Push to FIFO i when `ini_valid && ini_ready`.
- `ini_ready = (count_i != DEPTH)`; this is registered state only, with no pop-bypass. A full FIFO stays not-ready in the cycle it is popped.
- Request: `request[i] = (count_i != 0)`, decoded from registered count.
- Eligibility: `elig = grant & request`. Grant bits for empty FIFOs are ignored.
- Selection:
  - `elig == 00`: no pop.
  - `elig == 01`: pop client 0.
  - `elig == 10`: pop client 1.
  - `elig == 11`: pop client `~last_src`.
- At most one pop per cycle, in total across both FIFOs.
- On pop:
  - `out_data <= head`, `out_src <= sel`, `out_valid <= 1`;
  - `last_src <= sel`;
  - the read pointer advances.
- On no pop: `out_valid <= 0`. `out_data` and `out_src` hold their values.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- There is no backpressure on the output bus; the consumer must accept every `out_valid` beat.

## Timing
- Reset values:
  - all FIFO counts and pointers 0;
  - `request = 00`;
  - `in0_ready = in1_ready = 1`;
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`;
  - `last_src = 1`, so client 0 wins the first tie.
- Reset mid-operation: all FIFO contents are discarded. Outputs take their reset values on the edge after `reset` is sampled high. Pushes and grants are ignored while `reset` is high.
- Push at edge N → `request[i]` high after edge N (next cycle).
- Grant sampled at edge N with `elig` set → `out_valid` high for one cycle after edge N. `count_i` decrements at the same edge.
- A word pushed at edge N can be popped at edge N+1 at the earliest. Minimum push-to-out latency is 2 edges.
- If the last entry is popped at edge N, `request[i]` falls after edge N. The arbiter must not rely on `request` staying high past a pop.

## Configuration
- `ARB_FE_STARVE_CNT_EN` defined:
  - adds outputs `starve0` and `starve1` (out, 8 bits each);
  - `starvei` increments, saturating at 255, every cycle `request[i]` is high and client i is not popped;
  - it clears to 0 on a pop from client i, and on reset.
- Not defined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: hold `reset` 5 cycles with valid inputs active.
  - Required: `request = 00`, both readies 1, `out_valid = 0` throughout. After release, the first push appears on `request` one cycle later.
- Single client:
  - Stimulus: push 0x11, 0x22 on client 0; then `grant = 01` for 3 cycles.
  - Required: outputs 0x11 then 0x22 with `out_src = 0`, then `out_valid = 0`. `request[0]` falls after the second pop.
- Tie-break:
  - Stimulus: FIFO 0 = {0xA0, 0xA1}, FIFO 1 = {0xB0, 0xB1}; `grant = 11` for 4 cycles.
  - Required: outputs in order 0xA0, 0xB0, 0xA1, 0xB1 with alternating `out_src`.
- Full FIFO:
  - Stimulus: push 4 words to client 1 with no grant.
  - Required: `in1_ready` goes 0 after the 4th push, and a 5th offered word is not accepted. Then `grant = 10` with push held: `in1_ready` returns 1 the cycle after the pop, and the 5th word is enqueued with the wrap-around read correct.
- Spurious grant:
  - Stimulus: FIFO 0 empty, FIFO 1 = {0x5C}; `grant = 01`, then `grant = 11`.
  - Required: no output on the first grant. The second grant yields 0x5C with `out_src = 1`.
- Starve counter (`ARB_FE_STARVE_CNT_EN` defined):
  - Stimulus: FIFO 0 holds one word, `grant = 00` for 300 cycles, then `grant = 01`.
  - Required: `starve0` saturates at 255, then reads 0 the cycle after the pop.
